uart_cmd_receiver: RTL and testbench
====================================

UART_CMD_RECEIVER -- requirements
Module: uart_cmd_receiver

Interface
REQ-001 SHALL have parameter CLK_FREQ, default 50_000_000, system clock frequency in Hz.
REQ-002 SHALL have parameter BAUD, default 115200, serial bit rate.
REQ-003 SHALL have parameter TIMEOUT_CYCLES, default 50_000, maximum idle gap between bytes inside a frame.
REQ-004 SHALL have port clk  input  1  system clock; all logic on rising edge.
REQ-005 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port uart_rx  input  1  asynchronous serial line, idle high, 8N1, LSB first.
REQ-007 SHALL have port cmd_valid  output  1  one-cycle pulse: a valid frame was received.
REQ-008 SHALL have port cmd  output  8  command byte of the last valid frame.
REQ-009 SHALL have port cmd_data  output  32  payload of the last valid frame; first payload byte in [31:24].
REQ-010 SHALL have port frame_err  output  1  one-cycle pulse: frame aborted (stop-bit error, checksum error or timeout).
REQ-011 SHALL have port busy  output  1  high while a frame is in progress (header accepted, frame not yet closed).

Function
REQ-012 SHALL pass uart_rx through a 2-flop synchronizer, reset value 1, before any use.
REQ-013 SHALL use CLKS_PER_BIT = CLK_FREQ/BAUD, integer truncation (434 at defaults).
REQ-014 Byte FSM SHALL have states IDLE, START, DATA, STOP.
- IDLE->START on synchronized line low.
- START: at CLKS_PER_BIT/2, line low -> DATA; line high -> IDLE (glitch, no error).
- DATA: 8 samples at CLKS_PER_BIT spacing, LSB first.
- STOP: one sample after CLKS_PER_BIT; high -> byte accepted; low -> stop error; both -> IDLE.
REQ-015 SHALL deliver an accepted byte to the frame FSM exactly one cycle after the stop-bit sample.
REQ-016 Frame FSM SHALL have states HDR, CMD, DATA, CSUM, with a 2-bit payload byte counter.
- HDR: byte 0xA5 -> CMD and busy=1; any other byte is dropped silently.
- CMD: store the byte as cmd, then -> DATA.
- DATA: shift 4 bytes in big-endian order, then -> CSUM (or close the frame when checksum is compiled out).
REQ-017 Checksum SHALL be the 8-bit sum mod 256 of the cmd byte and the 4 payload bytes.
REQ-018 On frame close with a match, SHALL update cmd and cmd_data, pulse cmd_valid in the same cycle, and return to HDR.
REQ-019 On a checksum mismatch, SHALL pulse frame_err, leave cmd and cmd_data unchanged, and return to HDR.
REQ-020 A stop error while busy=1 SHALL abort the frame with a frame_err pulse; a stop error in HDR SHALL be ignored.
REQ-021 Timeout SHALL be measured as cycles since the last accepted byte while busy=1.
- Reaching TIMEOUT_CYCLES with the byte FSM in IDLE SHALL pulse frame_err and return to HDR.
- An ongoing byte SHALL suppress the timeout.
REQ-022 A 0xA5 byte after the header SHALL be treated as data, not as a resync.
REQ-023 cmd_valid and frame_err SHALL never be high in the same cycle.
REQ-024 busy SHALL drop in the cycle that cmd_valid or frame_err is asserted.
REQ-025 Back-to-back frames with zero idle gap SHALL all be received.

Reset
REQ-026 On rst_n low, SHALL immediately set:
- Both FSMs to IDLE/HDR; counters to 0; synchronizer to 1.
- cmd_valid=0, frame_err=0, busy=0, cmd=0x00, cmd_data=0x00000000.
REQ-027 Reset mid-frame SHALL discard the partial frame and raise no error pulse after release.

Configuration
REQ-028 Macro CMD_RX_CHECKSUM_EN SHALL select the checksum feature.
- Defined: frame is 7 bytes (A5, cmd, d0..d3, csum) and REQ-017/019 apply.
- Undefined: frame is 6 bytes, it closes valid after d3, no CSUM state exists, and only stop-error or timeout can raise frame_err.

Verification
REQ-029 Checksum on, send A5 01 12 34 56 78 15 at 115200 -> one cmd_valid; cmd=0x01, cmd_data=0x12345678, frame_err=0.
REQ-030 Same frame with csum 0x16 -> one frame_err pulse; cmd and cmd_data keep their previous values.
REQ-031 Send 0x00, 0xFF, then a valid frame -> the leading bytes are ignored; exactly one cmd_valid.
REQ-032 Send A5 02 then idle 60_000 cycles -> frame_err at 50_000 cycles after the 02 byte; busy=0 afterwards.
REQ-033 Send A5 01 with a forced-low stop bit on the 3rd byte -> frame_err; the next valid frame is accepted.
REQ-034 Checksum off, send A5 03 00 00 00 2A -> cmd_valid; cmd=0x03, cmd_data=0x0000002A.

Source files
------------

// File: rtl/uart_cmd_receiver.sv
// uart_cmd_receiver: 8N1 UART byte receiver feeding an 0xA5-framed command parser
// Ports:
//   clk       - system clock, rising edge
//   rst_n     - asynchronous active-low reset
//   uart_rx   - asynchronous serial input, idle high, 8N1, LSB first
//   cmd_valid - one-cycle pulse when a complete valid frame closes
//   cmd       - command byte of the last valid frame
//   cmd_data  - 32-bit payload of the last valid frame, first payload byte in [31:24]
//   frame_err - one-cycle pulse when a frame aborts (stop error, checksum error, timeout)
//   busy      - high from header acceptance until the frame closes
// Build option: define CMD_RX_CHECKSUM_EN to require a trailing mod-256 checksum byte
module uart_cmd_receiver #(
  parameter int CLK_FREQ       = 50_000_000,
  parameter int BAUD           = 115200,
  parameter int TIMEOUT_CYCLES = 50_000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        uart_rx,
  output logic        cmd_valid,
  output logic [7:0]  cmd,
  output logic [31:0] cmd_data,
  output logic        frame_err,
  output logic        busy
);
  localparam int CPB  = CLK_FREQ / BAUD;
  localparam int HALF = CPB / 2;
  localparam int CW   = $clog2(CPB + 1);
  localparam int TW   = $clog2(TIMEOUT_CYCLES + 1);
  typedef enum logic [1:0] {B_IDLE, B_START, B_DATA, B_STOP} byte_state_t;
`ifdef CMD_RX_CHECKSUM_EN
  typedef enum logic [1:0] {F_HDR, F_CMD, F_DATA, F_CSUM} frame_state_t;
`else
  typedef enum logic [1:0] {F_HDR, F_CMD, F_DATA} frame_state_t;
`endif
  logic [1:0]    r_sync;
  byte_state_t   r_bstate;
  logic [CW-1:0] r_cnt;
  logic [2:0]    r_bit;
  logic [7:0]    r_shift;
  logic          r_byte_vld;
  logic          r_stop_err;
  frame_state_t  r_fstate;
  logic [1:0]    r_pcnt;
  logic [7:0]    r_cmd_tmp;
`ifdef CMD_RX_CHECKSUM_EN
  logic [31:0]   r_data_tmp;
  logic [7:0]    r_sum;
`else
  logic [23:0]   r_data_tmp;
`endif
  logic [TW-1:0] r_tcnt;
  logic          w_rx;
  logic          w_bit_end;
  logic          w_half_end;
  logic          w_tmax;
  logic          w_timeout;
  logic [31:0]   w_data_next;

  assign w_rx        = r_sync[1];
  assign w_bit_end   = r_cnt == CW'(CPB - 1);
  assign w_half_end  = r_cnt == CW'(HALF - 1);
  assign w_tmax      = r_tcnt == TW'(TIMEOUT_CYCLES - 1);
  // a byte in flight holds off the timeout; the counter saturates meanwhile
  assign w_timeout   = busy && w_tmax && r_bstate == B_IDLE;
  // r_shift holds the delivered byte until the next byte's data phase starts
  assign w_data_next = {r_data_tmp[23:0], r_shift};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_sync <= 2'b11;
    else        r_sync <= {r_sync[0], uart_rx};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_bstate   <= B_IDLE;
      r_cnt      <= '0;
      r_bit      <= '0;
      r_shift    <= '0;
      r_byte_vld <= 1'b0;
      r_stop_err <= 1'b0;
    end else begin
      r_byte_vld <= 1'b0;
      r_stop_err <= 1'b0;
      case (r_bstate)
        B_IDLE: begin
          r_cnt <= '0;
          r_bit <= '0;
          if (!w_rx) r_bstate <= B_START;
        end
        B_START: begin
          r_cnt <= w_half_end ? '0 : r_cnt + 1'b1;
          if (w_half_end) r_bstate <= w_rx ? B_IDLE : B_DATA;
        end
        B_DATA: begin
          r_cnt <= w_bit_end ? '0 : r_cnt + 1'b1;
          if (w_bit_end) begin
            r_shift <= {w_rx, r_shift[7:1]};
            r_bit   <= r_bit + 3'd1;
            if (r_bit == 3'd7) r_bstate <= B_STOP;
          end
        end
        default: begin
          r_cnt <= w_bit_end ? '0 : r_cnt + 1'b1;
          if (w_bit_end) begin
            r_byte_vld <= w_rx;
            r_stop_err <= ~w_rx;
            r_bstate   <= B_IDLE;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_fstate   <= F_HDR;
      r_pcnt     <= '0;
      r_cmd_tmp  <= '0;
      r_data_tmp <= '0;
      r_tcnt     <= '0;
      cmd_valid  <= 1'b0;
      frame_err  <= 1'b0;
      busy       <= 1'b0;
      cmd        <= '0;
      cmd_data   <= '0;
`ifdef CMD_RX_CHECKSUM_EN
      r_sum      <= '0;
`endif
    end else begin
      cmd_valid <= 1'b0;
      frame_err <= 1'b0;
      if (r_stop_err && busy) begin
        frame_err <= 1'b1;
        busy      <= 1'b0;
        r_fstate  <= F_HDR;
      end else if (r_byte_vld) begin
        r_tcnt <= '0;
        case (r_fstate)
          F_HDR: if (r_shift == 8'hA5) begin
            busy     <= 1'b1;
            r_fstate <= F_CMD;
          end
          F_CMD: begin
            r_cmd_tmp <= r_shift;
            r_pcnt    <= '0;
            r_fstate  <= F_DATA;
`ifdef CMD_RX_CHECKSUM_EN
            r_sum     <= r_shift;
`endif
          end
          F_DATA: begin
            r_pcnt     <= r_pcnt + 2'd1;
`ifdef CMD_RX_CHECKSUM_EN
            r_data_tmp <= w_data_next;
            r_sum      <= r_sum + r_shift;
            if (r_pcnt == 2'd3) r_fstate <= F_CSUM;
`else
            r_data_tmp <= w_data_next[23:0];
            if (r_pcnt == 2'd3) begin
              cmd       <= r_cmd_tmp;
              cmd_data  <= w_data_next;
              cmd_valid <= 1'b1;
              busy      <= 1'b0;
              r_fstate  <= F_HDR;
            end
`endif
          end
`ifdef CMD_RX_CHECKSUM_EN
          F_CSUM: begin
            cmd_valid <= r_shift == r_sum;
            frame_err <= r_shift != r_sum;
            if (r_shift == r_sum) begin
              cmd      <= r_cmd_tmp;
              cmd_data <= r_data_tmp;
            end
            busy     <= 1'b0;
            r_fstate <= F_HDR;
          end
`endif
          default: r_fstate <= F_HDR;
        endcase
      end else if (w_timeout) begin
        frame_err <= 1'b1;
        busy      <= 1'b0;
        r_fstate  <= F_HDR;
      end else if (busy && !w_tmax) begin
        r_tcnt <= r_tcnt + 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_uart_cmd_receiver.sv
// tb_uart_cmd_receiver: directed and randomized frames checked against a frame-level model
module tb_uart_cmd_receiver;
  localparam int CF  = 800_000;
  localparam int BD  = 100_000;
  localparam int CPB = CF / BD;
  localparam int TO  = 300;
`ifdef CMD_RX_CHECKSUM_EN
  localparam bit CSUM = 1'b1;
`else
  localparam bit CSUM = 1'b0;
`endif
  typedef struct {
    bit          err;
    logic [7:0]  c;
    logic [31:0] d;
    int          t;
  } ev_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        uart_rx = 1'b1;
  logic        cmd_valid;
  logic        frame_err;
  logic        busy;
  logic [7:0]  cmd;
  logic [31:0] cmd_data;
  int          n_cmp = 0;
  int          n_err = 0;
  int          cyc = 0;
  ev_t         evq[$];
  logic [7:0]  m_cmd = 8'h00;
  logic [31:0] m_data = 32'h0;

  uart_cmd_receiver #(.CLK_FREQ(CF), .BAUD(BD), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst_n(rst_n), .uart_rx(uart_rx), .cmd_valid(cmd_valid),
    .cmd(cmd), .cmd_data(cmd_data), .frame_err(frame_err), .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) if (rst_n && (cmd_valid || frame_err)) begin
    chk("pulse_exclusive", {63'd0, cmd_valid & frame_err}, 64'd0);
    chk("busy_drop", {63'd0, busy}, 64'd0);
    evq.push_back('{frame_err, cmd, cmd_data, cyc});
  end

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] b, input bit bad_stop = 1'b0);
    logic [9:0] f;
    f = {~bad_stop, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      uart_rx = f[i];
      idle(CPB);
    end
    uart_rx = 1'b1;
  endtask

  function automatic logic [7:0] csum_of(input logic [7:0] c, input logic [31:0] d);
    return c + d[31:24] + d[23:16] + d[15:8] + d[7:0];
  endfunction

  task automatic send_frame(input logic [7:0] c, input logic [31:0] d, input int gap,
                            input logic [7:0] cs_xor = 8'h00);
    logic [7:0] b [7];
    b = '{8'hA5, c, d[31:24], d[23:16], d[15:8], d[7:0], csum_of(c, d) ^ cs_xor};
    for (int i = 0; i < (CSUM ? 7 : 6); i++) begin
      send_byte(b[i]);
      if (i < (CSUM ? 6 : 5)) idle(gap);
    end
  endtask

  task automatic wait_ev(input int n, input int budget);
    int k;
    k = 0;
    while (evq.size() < n && k < budget) begin
      idle(1);
      k++;
    end
    idle(4);
    chk("event_count", evq.size(), n);
  endtask

  task automatic expect_valid(input string tag, input logic [7:0] c, input logic [31:0] d);
    ev_t e;
    if (evq.size() != 0) begin
      e = evq.pop_front();
      chk({tag, "_kind"}, e.err, 0);
      chk({tag, "_cmd"}, e.c, c);
      chk({tag, "_data"}, e.d, d);
    end
    m_cmd  = c;
    m_data = d;
  endtask

  task automatic expect_err(input string tag, output int t);
    ev_t e;
    t = -1;
    if (evq.size() != 0) begin
      e = evq.pop_front();
      t = e.t;
      chk({tag, "_kind"}, e.err, 1);
      chk({tag, "_cmd_kept"}, e.c, m_cmd);
      chk({tag, "_data_kept"}, e.d, m_data);
    end
  endtask

  initial begin
    #900_000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0]  c;
    logic [31:0] d;
    logic [7:0]  qc[$];
    logic [31:0] qd[$];
    int          t0;
    int          t;
    idle(3);
    chk("rst_cmd_valid", cmd_valid, 0);
    chk("rst_frame_err", frame_err, 0);
    chk("rst_busy", busy, 0);
    chk("rst_cmd", cmd, 0);
    chk("rst_cmd_data", cmd_data, 0);
    rst_n = 1'b1;
    idle(5);
    send_frame(8'h03, 32'h0000002A, 0);
    wait_ev(1, 40);
    expect_valid("frame_03", 8'h03, 32'h0000002A);
    send_frame(8'h01, 32'h12345678, 3);
    wait_ev(1, 40);
    expect_valid("frame_01", 8'h01, 32'h12345678);
`ifdef CMD_RX_CHECKSUM_EN
    send_frame(8'h01, 32'h12345678, 3, 8'h03);
    wait_ev(1, 40);
    expect_err("bad_csum", t);
    chk("bad_csum_out_cmd", cmd, m_cmd);
    chk("bad_csum_out_data", cmd_data, m_data);
`endif
    c = 8'($urandom);
    d = $urandom;
    send_byte(8'h00);
    send_byte(8'hFF);
    send_frame(c, d, 2);
    wait_ev(1, 40);
    expect_valid("junk_lead", c, d);
    for (int k = 0; k < 8; k++) begin
      c = 8'($urandom_range(0, 255));
      d = $urandom;
      if (k % 3 == 0) d[31:24] = 8'hA5;
      if (k == 1) c = 8'hA5;
      if (k == 4) d[7:0] = 8'hA5;
      send_frame(c, d, (k % 2 == 1) ? int'($urandom_range(0, 40)) : 0);
      qc.push_back(c);
      qd.push_back(d);
    end
    wait_ev(8, 40);
    for (int k = 0; k < 8; k++) expect_valid($sformatf("b2b%0d", k), qc[k], qd[k]);
    send_byte(8'hA5);
    send_byte(8'h02);
    t0 = cyc;
    idle(2);
    chk("busy_in_frame", busy, 1);
    wait_ev(1, TO + 100);
    expect_err("timeout", t);
    chk("timeout_at", {63'd0, (t - t0 >= TO - CPB) && (t - t0 <= TO + CPB)}, 64'd1);
    chk("timeout_busy_after", busy, 0);
    send_byte(8'hA5);
    send_byte(8'h01);
    send_byte(8'h12, 1'b1);
    idle(3 * CPB);
    wait_ev(1, 40);
    expect_err("stop_err", t);
    c = 8'($urandom);
    d = $urandom;
    send_frame(c, d, 1);
    wait_ev(1, 40);
    expect_valid("after_stop_err", c, d);
    send_byte(8'h5A, 1'b1);
    idle(3 * CPB);
    c = 8'($urandom);
    d = $urandom;
    send_frame(c, d, 0);
    wait_ev(1, 40);
    expect_valid("hdr_stop_err_ignored", c, d);
    send_byte(8'hA5);
    send_byte(8'h77);
    send_byte(8'h11);
    uart_rx = 1'b0;
    idle(3 * CPB);
    rst_n = 1'b0;
    #1;
    chk("midrst_cmd", cmd, 0);
    chk("midrst_cmd_data", cmd_data, 0);
    chk("midrst_busy", busy, 0);
    m_cmd  = 8'h00;
    m_data = 32'h0;
    uart_rx = 1'b1;
    idle(2);
    rst_n = 1'b1;
    wait_ev(0, TO + 100);
    c = 8'($urandom);
    d = $urandom;
    send_frame(c, d, 4);
    wait_ev(1, 40);
    expect_valid("after_reset", c, d);
    chk("final_cmd", cmd, m_cmd);
    chk("final_cmd_data", cmd_data, m_data);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
